// File: rtl/echo_gain_datapath_pkg.sv
// Shared constants, tap-count encoding and output saturation for the echo mixer.
package echo_pkg;

   localparam int GAIN_MAX  = 20;
   localparam int TAP1_DIV  = 20;
   localparam int TAP2_DIV  = 80;
   localparam int TAP2_MULT = 3;
   localparam int SUM_W     = 19;

   typedef enum logic [1:0] {
      REP_DRY = 2'b00,
      REP_ONE = 2'b01,
      REP_TWO = 2'b10
   } rep_e;

   localparam logic signed [SUM_W-1:0] SAT_HI = 19'sd32767;
   localparam logic signed [SUM_W-1:0] SAT_LO = -19'sd32768;

   function automatic logic signed [15:0] sat16(input logic signed [SUM_W-1:0] v);
      if (v > SAT_HI)
         return 16'sh7fff;
      else if (v < SAT_LO)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/echo_gain_datapath_sdiv_const.sv
// Combinational signed divide by a fixed constant, rounding toward zero.
module sdiv_const #(
   parameter int DATA_W  = 16,
   parameter int QW      = 12,
   parameter int DIVISOR = 20
) (
   input  logic signed [DATA_W-1:0] din,
   output logic signed [QW-1:0]     quot
);

   int q_full;

   // Integer division of a signed operand already truncates toward zero.
   assign q_full = int'(din) / DIVISOR;
   assign quot   = QW'(q_full);

endmodule

// File: rtl/echo_gain_datapath.sv
// Two-tap feed-forward echo mixer: divide, scale and mix delayed taps with the
// dry sample, saturate, and register through a two-stage pipeline.
module echo_gain_datapath #(
   parameter int DATA_W   = 16,
   parameter int GAIN_W   = 5,
   parameter int GAIN_MAX = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic                     bypass,
   input  logic [GAIN_W-1:0]        delay_gain,
   input  logic [1:0]               repeat_sel,
   input  logic signed [DATA_W-1:0] x_n,
   input  logic signed [DATA_W-1:0] x_n_1,
   input  logic signed [DATA_W-1:0] x_n_2,
   output logic signed [DATA_W-1:0] out,
   output logic                     out_valid
);

   import echo_pkg::*;

   localparam int Q1_W = 12;
   localparam int Q2_W = 10;
   localparam int P_W  = 18;

   localparam logic [GAIN_W-1:0]     GMAX  = GAIN_W'(GAIN_MAX);
   localparam logic signed [P_W-1:0] MULT3 = P_W'(TAP2_MULT);

   logic [GAIN_W-1:0]     geff;
   logic signed [Q1_W-1:0] q1;
   logic signed [Q2_W-1:0] q2;
   logic signed [P_W-1:0]  g1;
   logic signed [P_W-1:0]  g3;
   logic signed [P_W-1:0]  p1;
   logic signed [P_W-1:0]  p2;

   logic                     s1_valid;
   logic                     s1_bypass;
   rep_e                     s1_rep;
   logic signed [DATA_W-1:0] s1_x;
   logic signed [P_W-1:0]    s1_p1;
   logic signed [P_W-1:0]    s1_p2;

   logic signed [SUM_W-1:0]  sum1;
   logic signed [SUM_W-1:0]  sum2;
   logic signed [DATA_W-1:0] mix;

   assign geff = (delay_gain > GMAX) ? GMAX : delay_gain;

   sdiv_const #(.DATA_W(DATA_W), .QW(Q1_W), .DIVISOR(TAP1_DIV)) u_div_tap1 (
      .din  (x_n_1),
      .quot (q1)
   );

   sdiv_const #(.DATA_W(DATA_W), .QW(Q2_W), .DIVISOR(TAP2_DIV)) u_div_tap2 (
      .din  (x_n_2),
      .quot (q2)
   );

   // Dividing first loses precision on purpose; it keeps the multipliers narrow.
   assign g1 = signed'(P_W'(geff));
   assign g3 = g1 * MULT3;
   assign p1 = P_W'(q1) * g1;
   assign p2 = P_W'(q2) * g3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_bypass <= 1'b0;
         s1_rep    <= REP_DRY;
         s1_x      <= '0;
         s1_p1     <= '0;
         s1_p2     <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_bypass <= bypass;
            s1_rep    <= rep_e'(repeat_sel);
            s1_x      <= x_n;
            s1_p1     <= p1;
            s1_p2     <= p2;
         end
      end
   end

   assign sum1 = SUM_W'(s1_x) + SUM_W'(s1_p1);
   assign sum2 = sum1 + SUM_W'(s1_p2);

   // Encoding 2'b11 falls through to the two-tap mix.
   always_comb begin
      mix = s1_x;
      if (s1_bypass || s1_rep == REP_DRY)
         mix = s1_x;
      else if (s1_rep == REP_ONE)
         mix = DATA_W'(sat16(sum1));
      else
         mix = DATA_W'(sat16(sum2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid)
            out <= mix;
      end
   end

endmodule

// File: tb/tb_echo_gain_datapath.sv
// Self-checking bench for echo_gain_datapath: directed cases plus random
// streaming against an arithmetic reference with a due-cycle expectation queue.
module tb_echo_gain_datapath;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               bypass;
   logic [4:0]         delay_gain;
   logic [1:0]         repeat_sel;
   logic signed [15:0] x_n;
   logic signed [15:0] x_n_1;
   logic signed [15:0] x_n_2;
   logic signed [15:0] out;
   logic               out_valid;

   typedef struct {
      int due;
      int val;
   } exp_t;

   exp_t q[$];
   int   cyc;
   int   last_out;
   int   n_cmp;
   int   n_err;

   echo_gain_datapath dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .bypass     (bypass),
      .delay_gain (delay_gain),
      .repeat_sel (repeat_sel),
      .x_n        (x_n),
      .x_n_1      (x_n_1),
      .x_n_2      (x_n_2),
      .out        (out),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int clamp16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int mix_ref(input bit byp, input int g, input int rep,
                                  input int x0, input int x1, input int x2);
      int ge;
      int s1;
      int s2;
      ge = (g > 20) ? 20 : g;
      s1 = x0 + (x1 / 20) * ge;
      s2 = s1 + (x2 / 80) * (3 * ge);
      if (byp || rep == 0) return x0;
      if (rep == 1)        return clamp16(s1);
      return clamp16(s2);
   endfunction

   task automatic check_out();
      exp_t e;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         check("out_valid", int'(out_valid), 1);
         check("out", int'(out), e.val);
         last_out = e.val;
      end else begin
         check("out_valid_idle", int'(out_valid), 0);
         check("out_hold", int'(out), last_out);
      end
   endtask

   task automatic cycle(input bit v, input bit byp, input int g, input int rep,
                        input int x0, input int x1, input int x2);
      exp_t e;
      @(negedge clk);
      check_out();
      in_valid   = v;
      bypass     = byp;
      delay_gain = 5'(g);
      repeat_sel = 2'(rep);
      x_n        = 16'(x0);
      x_n_1      = 16'(x1);
      x_n_2      = 16'(x2);
      if (v) begin
         e.due = cyc + 2;
         e.val = mix_ref(byp, g, rep, x0, x1, x2);
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, 0, 0, 0, 0, 0);
   endtask

   function automatic int rand_sample();
      logic signed [15:0] s;
      case ($urandom_range(0, 7))
         0:       s = 16'sh7fff;
         1:       s = 16'sh8000;
         default: s = 16'($urandom);
      endcase
      return int'(s);
   endfunction

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      last_out = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b1;
      bypass     = 1'b0;
      delay_gain = 5'd17;
      repeat_sel = 2'b10;
      x_n        = 16'sd1111;
      x_n_1      = -16'sd2222;
      x_n_2      = 16'sd3333;
      #1;
      check("rst_out", int'(out), 0);
      check("rst_out_valid", int'(out_valid), 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_out", int'(out), 0);
      check("rst_hold_out_valid", int'(out_valid), 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      idle(2);
      // bypass, one tap, dry, two taps negative, truncation
      cycle(1, 1, 20, 2, 1234, 5000, 0);
      idle(2);
      cycle(1, 0, 10, 1, 1000, 2000, 0);
      cycle(1, 0, 10, 0, 1000, 2000, 0);
      cycle(1, 0, 20, 2, 0, -400, 800);
      cycle(1, 0, 20, 2, 5, -19, 79);
      // saturation and gain clamp
      cycle(1, 0, 31, 2, 32767, 32767, 32767);
      cycle(1, 0, 31, 2, -32768, -32768, -32768);
      cycle(1, 0, 31, 1, 0, 2000, 0);
      cycle(1, 0, 20, 1, 0, 2000, 0);
      // zero gain is dry for every tap setting
      for (int r = 0; r < 4; r++)
         cycle(1, 0, 0, r, -777, 30000, -30000);
      idle(3);

      // back-to-back with settings toggling, then a 3-cycle gap
      for (int i = 0; i < 8; i++)
         cycle(1, 0, (i % 2) ? 31 : 7, (i % 2) ? 1 : 3,
               rand_sample(), rand_sample(), rand_sample());
      idle(3);
      for (int i = 0; i < 4; i++)
         cycle(1, 0, 13, 2, rand_sample(), rand_sample(), rand_sample());
      idle(3);

      // reset asserted mid-stream clears output immediately
      cycle(1, 1, 5, 1, 4321, 0, 0);
      cycle(1, 0, 20, 1, 100, 20000, 0);
      cycle(1, 0, 20, 2, 100, 20000, -8000);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_out", int'(out), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      q.delete();
      last_out = 0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      cycle(1, 0, 9, 1, -5000, -12345, 0);
      idle(3);

      // random streaming
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
               rand_sample(), rand_sample(), rand_sample());
      idle(4);
      check("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/echo_gain_datapath.md
Name: echo_gain_datapath

Overview:
Two-tap feed-forward echo mixer for the guitar-effects audio path. It sits between the sample delay line, which supplies x(n), x(n-1) and x(n-2), and the output register stage.
- It scales the delayed taps by a user gain using constant division, multiplication and addition.
- It mixes the scaled taps with the dry sample.
- It saturates the sum and registers the result through a 2-stage pipeline.
- Bypass passes the dry sample through unchanged.

Parameters:
DATA_W, 16, sample width (signed two's complement)
GAIN_W, 5, gain control width
GAIN_MAX, 20, maximum effective gain; larger codes clamp to this

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample set valid this cycle
bypass  in  1  1 = output dry x(n)
delay_gain  in  GAIN_W  gain G, unsigned
repeat_sel  in  2  echo tap count: 00 dry, 01 one tap, 10 or 11 two taps
x_n  in  DATA_W  current sample, signed
x_n_1  in  DATA_W  sample delayed once, signed
x_n_2  in  DATA_W  sample delayed twice, signed
out  out  DATA_W  mixed sample, signed, registered
out_valid  out  1  out holds a new result

Behaviour:
- Reset (rst_n low, asynchronous): out=0, out_valid=0, all pipeline registers cleared. Reset released mid-stream: the first valid output appears 2 cycles after the first in_valid following release.
- Geff = min(delay_gain, 20). Evaluate this in stage 1.
- Stage 1 (registered on in_valid):
  - q1 = x_n_1 / 20, signed, truncated toward zero.
  - q2 = x_n_2 / 80, signed, truncated toward zero.
  - p1 = q1 * Geff.
  - p2 = q2 * (3*Geff).
  - Register x_n, p1, p2, bypass and repeat_sel alongside.
  - Widths: q1 ≥ 12 bits, q2 ≥ 10 bits, p1/p2 ≥ 18 bits signed.
- Division happens before multiplication; the precision loss from this ordering is intentional.
- Stage 2:
  - s1 = x_n + p1.
  - s2 = s1 + p2.
  - All sums are computed at ≥ 19 bits signed, then saturated to [-32768, 32767].
  - Selection, in priority order:
    - bypass=1: out = x_n, unsaturated and bit-exact.
    - repeat_sel=00: out = x_n.
    - repeat_sel=01: out = sat(s1).
    - repeat_sel=1x: out = sat(s2).
- Latency: exactly 2 clk cycles from in_valid to out_valid, with full throughput (one sample per cycle).
- When in_valid=0, the stage registers hold their values; out holds, and out_valid drops to 0 one stage later.
- Control inputs (bypass, delay_gain, repeat_sel) are sampled with the data in stage 1. A change therefore affects only samples accepted from that cycle on; samples already in the pipeline are not affected.
- Geff=0: out equals x_n for every repeat_sel.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package echo_pkg holds:
  - constants GAIN_MAX=20, TAP1_DIV=20, TAP2_DIV=80, TAP2_MULT=3;
  - a repeat_sel enumeration (REP_DRY, REP_ONE, REP_TWO);
  - a saturation function sat16.
- One sub-module, sdiv_const: signed divide-by-constant, parameterized by divisor, combinational, truncating toward zero. It is instantiated twice (divisors 20 and 80).
- Multipliers and adders are inline.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs → out=0, out_valid=0 immediately (asynchronous). Release rst_n, apply in_valid → out_valid rises after 2 cycles.
- Bypass: bypass=1, x_n=1234, x_n_1=5000, G=20, repeat_sel=10 → out=1234 after 2 cycles.
- One tap: repeat_sel=01, G=10, x_n=1000, x_n_1=2000 → q1=100, p1=1000, out=2000. The same inputs with repeat_sel=00 → out=1000.
- Two taps, negative: repeat_sel=10, G=20, x_n=0, x_n_1=-400, x_n_2=800 → p1=-400, p2=600, out=200. Truncation check: x_n_1=-19, x_n_2=79, x_n=5 → out=5.
- Saturation and clamp:
  - repeat_sel=10, G=31 (clamps to 20), all samples 32767 → out=32767.
  - All samples -32768 → out=-32768.
  - G=31 gives the same result as G=20 for x_n_1=2000, x_n=0, repeat_sel=01 → out=2000.
- Streaming: 8 back-to-back valid samples with G and repeat_sel toggling every cycle → each output matches its own sample's settings. An in_valid gap of 3 cycles → out holds and out_valid=0 during the gap.
